catcore_cmd_dispatcher: RTL and testbench

Parametrised CatCore command engine. Accepts validated UART frames from the UART core's RX side and decodes the opcode and endchar. It drives a bank of NUM_CH independent PWM LED channels with glitch-free duty/period updates, and queues one response frame to the UART TX side with busy handshaking. It replaces the single global PWM and the ad-hoc in-line frame decoding in the top level.

---
 rtl/catcore_cmd_dispatcher.sv | 212 +++++++++++++++++++++
 tb/tb_catcore_cmd_dispatcher.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/catcore_cmd_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : catcore_cmd_dispatcher                                       |
// | Description : CatCore command engine. Takes validated UART RX frames,      |
// |               checks opcode/endchar, executes the command against a bank   |
// |               of NUM_CH PWM LED channels and queues one response frame to  |
// |               the UART TX side, honouring tx_busy backpressure.            |
// | Ports       : clk, nreset (sync, active-low)                               |
// |               frame_valid/frame_data/frame_ready : RX frame handshake      |
// |               tx_busy/tx_start/tx_data            : TX response handshake  |
// |               led_out   : registered PWM outputs, bit n = channel n        |
// |               err_count : saturating count of rejected frames              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module catcore_cmd_dispatcher #(
   parameter int FRAME_BYTES = 18,
   parameter int NUM_CH      = 8,
   parameter int PWM_BITS    = 8,
   parameter int ERR_BITS    = 8
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     frame_valid,
   input  logic [FRAME_BYTES*8-1:0] frame_data,
   output logic                     frame_ready,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [FRAME_BYTES*8-1:0] tx_data,
   output logic [NUM_CH-1:0]        led_out,
   output logic [ERR_BITS-1:0]      err_count
);

   localparam int c_FW = FRAME_BYTES * 8;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_CHECK = 2'd1;
   localparam logic [1:0] c_EXEC  = 2'd2;
   localparam logic [1:0] c_RESP  = 2'd3;

   localparam logic [7:0] c_OP_L    = 8'h4C;  // "L"
   localparam logic [7:0] c_OP_R    = 8'h52;  // "R"
   localparam logic [7:0] c_OP_X    = 8'h58;  // "X"
   localparam logic [7:0] c_OP_E    = 8'h45;  // "E"
   localparam logic [7:0] c_CH_BASE = 8'h41;  // "A"
   localparam logic [7:0] c_RD_TAG  = 8'h72;  // "r"

   // Right-justified, zero-filled, exactly as a string assignment would be
   localparam logic [c_FW-1:0] c_RESP_OK  = c_FW'("ok");
   localparam logic [c_FW-1:0] c_RESP_INV = c_FW'("invalid instruct");

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic [c_FW-1:0]     r_frame;
   logic [c_FW-1:0]     r_tx_data;
   logic [ERR_BITS-1:0] r_err;

   logic [PWM_BITS-1:0] r_duty      [NUM_CH];
   logic [PWM_BITS-1:0] r_period    [NUM_CH];
   logic [PWM_BITS-1:0] r_cnt       [NUM_CH];
   logic [PWM_BITS-1:0] r_sh_duty   [NUM_CH];
   logic [PWM_BITS-1:0] r_sh_period [NUM_CH];
   logic [NUM_CH-1:0]   r_pending;
   logic [NUM_CH-1:0]   r_led;

   // ---------------- frame decode ----------------
   logic [7:0] w_op, w_byte1, w_byte2, w_byte3, w_endc, w_ch;
   logic       w_known, w_needs_ch, w_ch_ok, w_valid;
   logic       w_unused_frame;

   assign w_op    = r_frame[7:0];
   assign w_byte1 = r_frame[15:8];
   assign w_byte2 = r_frame[23:16];
   assign w_byte3 = r_frame[31:24];
   assign w_endc  = r_frame[c_FW-1 -: 8];
   assign w_unused_frame = ^r_frame;

   // A byte1 below "A" wraps to a large value and is rejected by the range test
   assign w_ch       = w_byte1 - c_CH_BASE;
   assign w_ch_ok    = (w_ch < 8'(NUM_CH));
   assign w_known    = (w_op == c_OP_L) || (w_op == c_OP_R) || (w_op == c_OP_X) || (w_op == c_OP_E);
   assign w_needs_ch = (w_op == c_OP_L) || (w_op == c_OP_R);
   assign w_valid    = (w_op == w_endc) && w_known && (!w_needs_ch || w_ch_ok);

   // Active-value read port for "R"
   logic [PWM_BITS-1:0] w_rd_duty, w_rd_period;
   logic [c_FW-1:0]     w_resp_r;

   always_comb begin
      w_rd_duty   = '0;
      w_rd_period = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (w_ch == 8'(n)) begin
            w_rd_duty   = r_duty[n];
            w_rd_period = r_period[n];
         end
      end
   end

   always_comb begin
      w_resp_r                = '0;
      w_resp_r[7:0]           = c_RD_TAG;
      w_resp_r[15:8]          = w_byte1;
      w_resp_r[23:16]         = 8'(w_rd_duty);
      w_resp_r[31:24]         = 8'(w_rd_period);
      w_resp_r[c_FW-1 -: 8]   = c_RD_TAG;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!nreset) r_state <= c_IDLE;
      else         r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (frame_valid) w_state_nxt = c_CHECK;
         c_CHECK: w_state_nxt = w_valid ? c_EXEC : c_RESP;
         c_EXEC:  w_state_nxt = c_RESP;
         c_RESP:  if (!tx_busy) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      frame_ready = (r_state == c_IDLE);
      tx_start    = (r_state == c_RESP) && !tx_busy;
   end

   // ---------------- datapath: frame, response, error counter ----------------
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_frame   <= '0;
         r_tx_data <= '0;
         r_err     <= '0;
      end else begin
         case (r_state)
            c_IDLE: if (frame_valid) r_frame <= frame_data;
            c_CHECK: begin
               if (!w_valid) begin
                  r_tx_data <= c_RESP_INV;
                  if (r_err != '1) r_err <= r_err + ERR_BITS'(1);
               end
            end
            c_EXEC: begin
               case (w_op)
                  c_OP_L, c_OP_X: r_tx_data <= c_RESP_OK;
                  c_OP_R:         r_tx_data <= w_resp_r;
                  c_OP_E: begin
                     r_tx_data <= c_FW'(r_err);
                     r_err     <= '0;
                  end
                  default: r_tx_data <= r_tx_data;
               endcase
            end
            default: ;
         endcase
      end
   end

   // ---------------- PWM bank ----------------
   logic w_wr_l, w_wr_x;
   assign w_wr_l = (r_state == c_EXEC) && (w_op == c_OP_L);
   assign w_wr_x = (r_state == c_EXEC) && (w_op == c_OP_X);

   always_ff @(posedge clk) begin
      for (int n = 0; n < NUM_CH; n++) begin
         if (!nreset) begin
            r_duty[n]      <= '0;
            r_period[n]    <= '0;
            r_cnt[n]       <= '0;
            r_sh_duty[n]   <= '0;
            r_sh_period[n] <= '0;
            r_pending[n]   <= 1'b0;
            r_led[n]       <= 1'b0;
         end else begin
            // Shadow values only become active at a wrap, so a period never
            // gets cut short or stretched by an update (no runt pulses).
            if (r_cnt[n] >= r_period[n]) begin
               r_cnt[n] <= '0;
               if (r_pending[n]) begin
                  r_duty[n]    <= r_sh_duty[n];
                  r_period[n]  <= r_sh_period[n];
                  r_pending[n] <= 1'b0;
               end
            end else begin
               r_cnt[n] <= r_cnt[n] + PWM_BITS'(1);
            end
            r_led[n] <= (r_cnt[n] < r_duty[n]);
            // A write wins over the wrap's pending clear: the wrap has taken
            // the old shadow, the new one waits for the next wrap.
            if (w_wr_l && (w_ch == 8'(n))) begin
               r_sh_duty[n]   <= PWM_BITS'(w_byte2);
               r_sh_period[n] <= PWM_BITS'(w_byte3);
               r_pending[n]   <= 1'b1;
            end
            if (w_wr_x) begin
               r_sh_duty[n] <= '0;
               r_pending[n] <= 1'b1;
            end
         end
      end
   end

   assign tx_data   = r_tx_data;
   assign led_out   = r_led;
   assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_catcore_cmd_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_catcore_cmd_dispatcher                                    |
// | Description : Self-checking bench for catcore_cmd_dispatcher. Expected    |
// |               responses are queued when a frame is sent and compared when  |
// |               tx_start is seen; LED behaviour is checked over windows.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_catcore_cmd_dispatcher;

   localparam int c_FB = 18;
   localparam int c_FW = c_FB * 8;
   localparam int c_NCH = 8;

   localparam logic [c_FW-1:0] c_OK  = c_FW'("ok");
   localparam logic [c_FW-1:0] c_INV = c_FW'("invalid instruct");

   logic              clk = 1'b0;
   logic              nreset;
   logic              frame_valid;
   logic [c_FW-1:0]   frame_data;
   logic              frame_ready;
   logic              tx_busy;
   logic              tx_start;
   logic [c_FW-1:0]   tx_data;
   logic [c_NCH-1:0]  led_out;
   logic [7:0]        err_count;

   catcore_cmd_dispatcher #(
      .FRAME_BYTES(c_FB), .NUM_CH(c_NCH), .PWM_BITS(8), .ERR_BITS(8)
   ) dut (
      .clk(clk), .nreset(nreset),
      .frame_valid(frame_valid), .frame_data(frame_data), .frame_ready(frame_ready),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .led_out(led_out), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pushed = 0;
   int n_resp   = 0;
   logic [c_FW-1:0] r_exp_q [$];
   int m_err = 0;
   logic [7:0] m_duty [c_NCH];
   logic [7:0] m_period [c_NCH];

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every tx_start pops one expected response
   always @(negedge clk) begin
      if (nreset === 1'b1 && tx_start === 1'b1) begin
         if (r_exp_q.size() == 0) begin
            chk("unexpected_tx_start", 160'(tx_start), 160'(0));
         end else begin
            chk("tx_data", 160'(tx_data), 160'(r_exp_q.pop_front()));
            n_resp++;
         end
      end
   end

   task automatic send(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] endc,
                       input logic push, input logic [c_FW-1:0] exp);
      int guard = 0;
      @(negedge clk);
      while (!frame_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!frame_ready) chk("ready_timeout", 160'(frame_ready), 160'(1));
      if (push) begin
         r_exp_q.push_back(exp);
         n_pushed++;
      end
      frame_data = '0;
      frame_data[7:0]   = op;
      frame_data[15:8]  = b1;
      frame_data[23:16] = b2;
      frame_data[31:24] = b3;
      frame_data[c_FW-1 -: 8] = endc;
      frame_valid = 1'b1;
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
   endtask

   task automatic wait_resp();
      int guard = 0;
      while (n_resp < n_pushed && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("resp_count", 160'(n_resp), 160'(n_pushed));
   endtask

   // "L" with model update; ch given as letter
   task automatic send_l(input logic [7:0] chr, input logic [7:0] d, input logic [7:0] p);
      int ch;
      ch = int'(chr) - 65;
      if (ch >= 0 && ch < c_NCH) begin
         m_duty[ch]   = d;
         m_period[ch] = p;
         send("L", chr, d, p, "L", 1'b1, c_OK);
      end else begin
         if (m_err < 255) m_err++;
         send("L", chr, d, p, "L", 1'b1, c_INV);
      end
   endtask

   task automatic send_inv(input logic [7:0] op, input logic [7:0] endc);
      if (m_err < 255) m_err++;
      send(op, "A", 8'd1, 8'd1, endc, 1'b1, c_INV);
   endtask

   task automatic send_e();
      logic [c_FW-1:0] exp;
      exp = c_FW'(m_err);
      m_err = 0;
      send("E", 8'd0, 8'd0, 8'd0, "E", 1'b1, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ones;
      logic [7:0] acc_or, acc_and;
      logic bad;
      logic prev;
      int guard;
      logic [29:0] rec, rec_exp;
      logic [c_FW-1:0] exp_r;

      for (int i = 0; i < c_NCH; i++) begin
         m_duty[i] = 8'd0;
         m_period[i] = 8'd0;
      end
      nreset = 1'b0; frame_valid = 1'b0; frame_data = '0; tx_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1 nreset = 1'b1;
      @(negedge clk);
      chk("rst_frame_ready", 160'(frame_ready), 160'(1));
      chk("rst_tx_start", 160'(tx_start), 160'(0));
      chk("rst_tx_data", 160'(tx_data), 160'(0));
      chk("rst_led", 160'(led_out), 160'(0));
      chk("rst_err", 160'(err_count), 160'(0));

      // Channel C: duty 3 / period 9, with response latency
      send_l("C", 8'd3, 8'd9);
      repeat (2) @(negedge clk);
      chk("ready_low_in_resp", 160'(frame_ready), 160'(0));
      @(negedge clk);
      chk("tx_start_latency", 160'(tx_start), 160'(1));
      @(negedge clk);
      chk("ready_after_resp", 160'(frame_ready), 160'(1));
      wait_resp();
      repeat (25) @(negedge clk);
      ones = 0; acc_or = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ones += int'(led_out[2]);
         acc_or |= led_out & ~8'h04;
      end
      chk("ch2_duty_3_of_10", 160'(ones), 160'(12));
      chk("other_ch_off", 160'(acc_or), 160'(0));

      // Channel A: 5/9 then retune to 1 mid-period (no runt)
      send_l("A", 8'd5, 8'd9);
      wait_resp();
      repeat (30) @(negedge clk);
      prev = led_out[0];
      guard = 0;
      @(negedge clk);
      while (!(led_out[0] && !prev) && guard < 100) begin
         prev = led_out[0];
         @(negedge clk);
         guard++;
      end
      chk("ch0_rise_found", 160'(led_out[0]), 160'(1));
      rec = '0;
      rec[0] = led_out[0];
      fork
         send_l("A", 8'd1, 8'd9);
         begin
            for (int i = 1; i < 30; i++) begin
               @(negedge clk);
               rec[i] = led_out[0];
            end
         end
      join
      for (int i = 0; i < 30; i++) rec_exp[i] = (i < 5) || (i == 10) || (i == 20);
      chk("ch0_no_runt", 160'(rec), 160'(rec_exp));
      wait_resp();

      // Edge cases: period 0 duty 1, duty > period, duty 0
      send_l("E", 8'd1, 8'd0);
      send_l("F", 8'd20, 8'd10);
      send_l("G", 8'd0, 8'd5);
      wait_resp();
      repeat (30) @(negedge clk);
      acc_or = '0; acc_and = '1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         acc_and &= led_out;
         acc_or  |= led_out;
      end
      chk("p0_d1_on", 160'(acc_and[4]), 160'(1));
      chk("d_gt_p_on", 160'(acc_and[5]), 160'(1));
      chk("d0_off", 160'(acc_or[6]), 160'(0));

      // "R" under tx_busy backpressure
      tx_busy = 1'b1;
      exp_r = '0;
      exp_r[7:0] = 8'h72; exp_r[15:8] = "C";
      exp_r[23:16] = m_duty[2]; exp_r[31:24] = m_period[2];
      exp_r[c_FW-1 -: 8] = 8'h72;
      send("R", "C", 8'd0, 8'd0, "R", 1'b1, exp_r);
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         bad |= frame_ready | tx_start;
      end
      chk("busy_backpressure", 160'(bad), 160'(0));
      @(posedge clk);
      #1 tx_busy = 1'b0;
      @(negedge clk);
      chk("tx_start_after_busy", 160'(tx_start), 160'(1));
      @(negedge clk);
      chk("tx_start_one_cycle", 160'(tx_start), 160'(0));
      wait_resp();

      // Rejections and "E"
      send_inv("L", "Q");
      send_inv("Z", "Z");
      send_l("J", 8'd1, 8'd1);
      wait_resp();
      chk("err_three", 160'(err_count), 160'(m_err));
      send_e();
      wait_resp();
      chk("err_cleared", 160'(err_count), 160'(0));
      send_l("H", 8'd0, 8'd4);
      send_l("I", 8'd0, 8'd4);
      wait_resp();
      chk("ch_boundary_err", 160'(err_count), 160'(1));
      send_e();
      wait_resp();

      // Saturation
      for (int i = 0; i < 260; i++) send_inv("Z", "Z");
      wait_resp();
      chk("err_saturated", 160'(err_count), 160'(255));
      send_e();
      wait_resp();
      chk("err_cleared_sat", 160'(err_count), 160'(0));

      // Reset while held in RESP
      tx_busy = 1'b1;
      send("Z", 8'd0, 8'd0, 8'd0, "Z", 1'b0, c_INV);
      repeat (5) @(negedge clk);
      chk("err_before_rst", 160'(err_count), 160'(1));
      chk("ready_low_before_rst", 160'(frame_ready), 160'(0));
      nreset = 1'b0;
      @(posedge clk);
      #1 nreset = 1'b1;
      m_err = 0;
      @(negedge clk);
      chk("mid_rst_ready", 160'(frame_ready), 160'(1));
      chk("mid_rst_led", 160'(led_out), 160'(0));
      chk("mid_rst_err", 160'(err_count), 160'(0));
      chk("mid_rst_tx_data", 160'(tx_data), 160'(0));
      tx_busy = 1'b0;
      acc_or = '0; bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         acc_or |= led_out;
         bad |= tx_start;
      end
      chk("post_rst_led_off", 160'(acc_or), 160'(0));
      chk("post_rst_no_tx", 160'(bad), 160'(0));

      // "X" blanks all channels
      send_l("C", 8'd3, 8'd9);
      send_l("D", 8'd7, 8'd9);
      wait_resp();
      repeat (30) @(negedge clk);
      acc_or = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         acc_or |= led_out;
      end
      chk("pre_x_leds", 160'(acc_or), 160'(8'h0C));
      send("X", 8'd0, 8'd0, 8'd0, "X", 1'b1, c_OK);
      wait_resp();
      repeat (30) @(negedge clk);
      acc_or = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         acc_or |= led_out;
      end
      chk("x_all_off", 160'(acc_or), 160'(0));
      chk("queue_drained", 160'(r_exp_q.size()), 160'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
